// File: rtl/seg_display_if.sv
// Sequencer-side bus for the seven-segment display peripheral.
// The sequencer (master) drives the instruction word and its enable.
// The display (slave) returns its value register, the multiplexed
// digit drive and the current scan index for observation.
//
// Handshake: there is no back-pressure. An instruction is consumed on
// every rising clock edge where inst_en is high; the peripheral is
// always ready, and inst is ignored whenever inst_en is low.
interface seg_display_if;
   logic [11:0] inst;       // [11:8] opcode, [7:0] immediate
   logic        inst_en;    // execute inst on this rising edge
   logic [15:0] value;      // current display value register
   logic [3:0]  anodes;     // active-low digit enables
   logic [7:0]  segments;   // active-low {dp,g,f,e,d,c,b,a}
   logic [1:0]  dbg_digit;  // scan state: digit index being prepared

   modport master (
      output inst, inst_en,
      input  value, anodes, segments, dbg_digit
   );

   modport slave (
      input  inst, inst_en,
      output value, anodes, segments, dbg_digit
   );
endinterface

// File: rtl/seg_display.sv
// Four-digit, time-multiplexed, common-anode seven-segment driver.
// It holds a 16-bit value plus per-digit blank and decimal-point masks,
// all loaded by 12-bit sequencer instructions. A free-running refresh
// counter steps the scan through digits 0..3. The anode and segment
// drive is registered, so the display lags internal state by one cycle.
module seg_display #(
   parameter int REFRESH_DIV = 50000
) (
   input logic        clock,
   input logic        reset,
   seg_display_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDL = 4'h1;
   localparam logic [3:0] OP_LDH = 4'h2;
   localparam logic [3:0] OP_CLR = 4'h3;
   localparam logic [3:0] OP_BLK = 4'h4;
   localparam logic [3:0] OP_INC = 4'h5;
   localparam logic [3:0] OP_DEC = 4'h6;
   localparam logic [3:0] OP_DPS = 4'h7;

   typedef enum logic [1:0] {
      DIGIT_0 = 2'd0,
      DIGIT_1 = 2'd1,
      DIGIT_2 = 2'd2,
      DIGIT_3 = 2'd3
   } digit_t;

   // Architectural registers
   logic [15:0]      r_value;
   logic [3:0]       r_blank;
   logic [3:0]       r_dp;
   logic [CNT_W-1:0] r_refresh;
   digit_t           r_digit;
   logic [3:0]       r_anodes;
   logic [7:0]       r_segments;

   // Combinational next-state and decode signals
   logic [3:0]       w_op;
   logic [7:0]       w_imm;
   logic [15:0]      w_value_next;
   logic [3:0]       w_blank_next;
   logic [3:0]       w_dp_next;
   logic             w_wrap;
   digit_t           w_digit_next;
   logic [3:0]       w_nibble;
   logic [6:0]       w_hex;
   logic [3:0]       w_anodes_next;
   logic [7:0]       w_segments_next;

   assign w_op   = bus.inst[11:8];
   assign w_imm  = bus.inst[7:0];
   assign w_wrap = (r_refresh == CNT_LAST);

   // Instruction decode: compute the register file update for this edge
   always_comb begin
      w_value_next = r_value;
      w_blank_next = r_blank;
      w_dp_next    = r_dp;
      if (bus.inst_en) begin
         case (w_op)
            OP_NOP: ;
            OP_LDL: w_value_next[7:0]  = w_imm;
            OP_LDH: w_value_next[15:8] = w_imm;
            OP_CLR: w_value_next       = 16'h0000;
            OP_BLK: w_blank_next       = w_imm[3:0];
            OP_INC: w_value_next       = r_value + 16'd1;
            OP_DEC: w_value_next       = r_value - 16'd1;
            OP_DPS: w_dp_next          = w_imm[3:0];
            default: ;  // 0x8-0xF are reserved and behave as NOP
         endcase
      end
   end

   // Value, blank and decimal-point registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_value <= 16'h0000;
         r_blank <= 4'h0;
         r_dp    <= 4'h0;
      end else begin
         r_value <= w_value_next;
         r_blank <= w_blank_next;
         r_dp    <= w_dp_next;
      end
   end

   // Refresh counter: free-running 0..REFRESH_DIV-1, never touched by instructions
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_refresh <= '0;
      end else if (w_wrap) begin
         r_refresh <= '0;
      end else begin
         r_refresh <= r_refresh + CNT_W'(1);
      end
   end

   // Scan state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_digit <= DIGIT_0;
      end else begin
         r_digit <= w_digit_next;
      end
   end

   // Scan next-state: advance one digit each time the refresh counter wraps
   always_comb begin
      w_digit_next = r_digit;
      if (w_wrap) begin
         case (r_digit)
            DIGIT_0: w_digit_next = DIGIT_1;
            DIGIT_1: w_digit_next = DIGIT_2;
            DIGIT_2: w_digit_next = DIGIT_3;
            DIGIT_3: w_digit_next = DIGIT_0;
            default: w_digit_next = DIGIT_0;
         endcase
      end
   end

   // Select the nibble belonging to the digit currently being scanned
   always_comb begin
      w_nibble = r_value[3:0];
      case (r_digit)
         DIGIT_0: w_nibble = r_value[3:0];
         DIGIT_1: w_nibble = r_value[7:4];
         DIGIT_2: w_nibble = r_value[11:8];
         DIGIT_3: w_nibble = r_value[15:12];
         default: w_nibble = r_value[3:0];
      endcase
   end

   // Hex to active-low {g,f,e,d,c,b,a}
   always_comb begin
      w_hex = 7'h7F;
      case (w_nibble)
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         4'hF: w_hex = 7'h0E;
         default: w_hex = 7'h7F;
      endcase
   end

   // Drive pattern for the scanned digit; a blanked digit turns everything off
   always_comb begin
      w_anodes_next   = 4'b1111;
      w_segments_next = 8'hFF;
      if (!r_blank[r_digit]) begin
         w_anodes_next   = ~(4'b0001 << r_digit);
         w_segments_next = {~r_dp[r_digit], w_hex};
      end
   end

   // Registered output stage keeps the pins glitch-free on digit changes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_anodes   <= 4'b1111;
         r_segments <= 8'hFF;
      end else begin
         r_anodes   <= w_anodes_next;
         r_segments <= w_segments_next;
      end
   end

   assign bus.value     = r_value;
   assign bus.anodes    = r_anodes;
   assign bus.segments  = r_segments;
   assign bus.dbg_digit = r_digit;

endmodule

// File: tb/tb_seg_display.sv
// Bench for seg_display with a fast refresh divider. A small reference
// model of the value/blank/dp registers and the scan position produces
// the expected value and display for each cycle; expectations are queued
// when the stimulus is driven and compared after the edge that produces them.
module tb_seg_display;

   localparam int REF = 4;

   logic clock = 1'b0;
   logic reset;

   seg_display_if bus ();

   seg_display #(.REFRESH_DIV(REF)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and reset
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;   // rising edges since reset release

   logic [15:0] m_value = 16'h0000;
   logic [3:0]  m_blank = 4'h0;
   logic [3:0]  m_dp    = 4'h0;
   logic [27:0] exp_q[$];   // {value, anodes, segments}

   // Active-low {g..a} patterns for hex digits 0..F
   logic [6:0] hex_tab [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [3:0] exp_an(input logic [1:0] d);
      if (m_blank[d]) return 4'b1111;
      return ~(4'b0001 << d);
   endfunction

   function automatic logic [7:0] exp_sg(input logic [1:0] d);
      logic [3:0] nib;
      if (m_blank[d]) return 8'hFF;
      nib = m_value[d*4 +: 4];
      return {~m_dp[d], hex_tab[nib]};
   endfunction

   task automatic model_apply(input logic [11:0] ins);
      case (ins[11:8])
         4'h1: m_value[7:0]  = ins[7:0];
         4'h2: m_value[15:8] = ins[7:0];
         4'h3: m_value       = 16'h0000;
         4'h4: m_blank       = ins[3:0];
         4'h5: m_value       = m_value + 16'd1;
         4'h6: m_value       = m_value - 16'd1;
         4'h7: m_dp          = ins[3:0];
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_value = 16'h0000;
      m_blank = 4'h0;
      m_dp    = 4'h0;
      cyc     = 0;
      exp_q.delete();
   endtask

   // One clock: drive ins/en, queue the expectation, check after the edge
   task automatic step(input logic [11:0] ins, input logic en);
      logic [1:0]  d_show;
      logic [11:0] disp;
      logic [27:0] got;
      d_show = 2'((cyc / REF) % 4);
      disp   = {exp_an(d_show), exp_sg(d_show)};
      if (en) model_apply(ins);
      exp_q.push_back({m_value, disp});
      bus.inst    = ins;
      bus.inst_en = en;
      @(posedge clock);
      #1;
      cyc++;
      bus.inst_en = 1'b0;
      got = exp_q.pop_front();
      check_eq("value",    32'(bus.value),     32'(got[27:12]));
      check_eq("anodes",   32'(bus.anodes),    32'(got[11:8]));
      check_eq("segments", 32'(bus.segments),  32'(got[7:0]));
      check_eq("digit",    32'(bus.dbg_digit), 32'((cyc / REF) % 4));
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] imm);
      step({op, imm}, 1'b1);
   endtask

   task automatic idle(input int n, input logic [11:0] ins);
      for (int i = 0; i < n; i++) step(ins, 1'b0);
   endtask

   // Scan until a given anode pattern appears (bounded), then check its segments
   task automatic wait_anodes(input string tag, input logic [3:0] target, input logic [7:0] seg);
      for (int i = 0; i < 40 && bus.anodes !== target; i++) step(12'h000, 1'b0);
      check_eq({tag, "_an"},  32'(bus.anodes),   32'(target));
      check_eq({tag, "_seg"}, 32'(bus.segments), 32'(seg));
   endtask

   initial begin
      bus.inst    = 12'h000;
      bus.inst_en = 1'b0;
      reset       = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_value", 32'(bus.value),    32'h0000);
      check_eq("rst_an",    32'(bus.anodes),   32'hF);
      check_eq("rst_seg",   32'(bus.segments), 32'hFF);
      reset = 1'b0;
      model_reset();

      // First edge after reset shows digit 0 of an all-zero value
      idle(1, 12'h000);
      check_eq("first_an",  32'(bus.anodes),   32'b1110);
      check_eq("first_seg", 32'(bus.segments), 32'hC0);
      idle(16, 12'h000);   // full scan plus wrap back to digit 0

      // Load F01A and read each digit literally
      issue(4'h1, 8'h1A);
      issue(4'h2, 8'hF0);
      check_eq("ldh_val", 32'(bus.value), 32'hF01A);
      wait_anodes("f01a_d0", 4'b1110, 8'h88);
      wait_anodes("f01a_d1", 4'b1101, 8'hF9);
      wait_anodes("f01a_d2", 4'b1011, 8'hC0);
      wait_anodes("f01a_d3", 4'b0111, 8'h8E);

      // Increment and decrement wrap-around
      issue(4'h1, 8'hFF);
      issue(4'h2, 8'hFF);
      issue(4'h5, 8'h00);
      check_eq("inc_wrap", 32'(bus.value), 32'h0000);
      issue(4'h6, 8'h00);
      check_eq("dec_wrap", 32'(bus.value), 32'hFFFF);

      // Blank digits 1 and 3 for a full scan
      issue(4'h4, 8'h0A);
      idle(17, 12'h000);
      issue(4'h4, 8'h00);

      // Decimal point on digit 0 only
      issue(4'h3, 8'h00);
      issue(4'h7, 8'h01);
      wait_anodes("dp_d0", 4'b1110, 8'h40);
      wait_anodes("dp_d1", 4'b1101, 8'hC0);

      // CLR present but not enabled, and reserved opcodes
      issue(4'h1, 8'h55);
      idle(3, 12'h300);
      check_eq("no_en_val", 32'(bus.value), 32'h0055);
      issue(4'h9, 8'hAA);
      issue(4'hF, 8'h12);
      issue(4'h0, 8'h34);
      check_eq("rsvd_val", 32'(bus.value), 32'h0055);

      // Random instruction stream, including edges where the digit advances
      for (int i = 0; i < 200; i++) begin
         step(12'($urandom_range(0, 12'hFFF)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a scan
      issue(4'h4, 8'h00);
      issue(4'h1, 8'h34);
      issue(4'h2, 8'h12);
      issue(4'h7, 8'h0F);
      idle(6, 12'h000);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_value", 32'(bus.value),    32'h0000);
      check_eq("async_an",    32'(bus.anodes),   32'hF);
      check_eq("async_seg",   32'(bus.segments), 32'hFF);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      idle(1, 12'h000);
      check_eq("post_rst_an",  32'(bus.anodes),   32'b1110);
      check_eq("post_rst_seg", 32'(bus.segments), 32'hC0);
      idle(8, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
